bcd_load_counter: RTL and testbench

BCD_LOAD_COUNTER -- requirements
Module: bcd_load_counter

---
 rtl/bcd_load_counter_pkg.sv | 17 +
 rtl/bcd_load_counter_if.sv | 29 ++
 rtl/bcd_digit_valid.sv | 12 +
 rtl/bcd_load_counter.sv | 137 +++++++++++++
 tb/tb_bcd_load_counter.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/bcd_load_counter_pkg.sv
// Shared types and constants for the loadable BCD counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_load_counter_pkg;

   localparam int BCD_W = 4;                          // bits per BCD digit
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;       // largest legal digit

   typedef logic [BCD_W-1:0] bcd_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_load_counter_if.sv
// Count control, digit-serial load handshake and counter outputs in one bundle.
// Latency: n/a (wires only).
// Backpressure: ld_ready from the counter gates ld_valid/ld_digit transfers.
// Ports: en, up, ld_valid, ld_digit driven by the master;
//        ld_ready, q, carry, err driven by the counter (slave).
interface bcd_load_counter_if
   import bcd_load_counter_pkg::*;
#(
   parameter int DIGITS = 2
);
   logic                    en;
   logic                    up;
   logic                    ld_valid;
   bcd_t                    ld_digit;
   logic                    ld_ready;
   logic [BCD_W*DIGITS-1:0] q;
   logic                    carry;
   logic                    err;

   modport master (
      output en, up, ld_valid, ld_digit,
      input  ld_ready, q, carry, err
   );

   modport slave (
      input  en, up, ld_valid, ld_digit,
      output ld_ready, q, carry, err
   );
endinterface

// File: rtl/bcd_digit_valid.sv
// Flags whether a 4-bit code is a legal BCD digit (0..9).
// Latency: combinational.
// Backpressure: none.
// Ports: code (in, 4 bits), ok (out, 1 = legal digit).
module bcd_digit_valid
   import bcd_load_counter_pkg::*;
(
   input  bcd_t code,
   output logic ok
);
   assign ok = (code <= BCD_MAX);
endmodule

// File: rtl/bcd_load_counter.sv
// Up/down BCD counter with a digit-serial (LS digit first) parallel load.
// Latency: count visible 1 cycle after en; loaded value visible the cycle after COMMIT.
// Backpressure: ld_ready is low only during the single COMMIT cycle.
// Ports: clk, rst (sync, active high), bus (bcd_load_counter_if.slave).
module bcd_load_counter
   import bcd_load_counter_pkg::*;
#(
   parameter int DIGITS = 2
)
(
   input  logic               clk,
   input  logic               rst,
   bcd_load_counter_if.slave  bus
);
   localparam int QW    = BCD_W * DIGITS;
   localparam int IDX_W = 2;

   state_t            state, state_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic [QW-1:0]     shadow, shadow_n;
   logic [QW-1:0]     q_r, q_n;
   logic              carry_r, carry_n;
   logic              err_r, err_n;

   logic              xfer;
   logic              dig_ok;
   logic [QW-1:0]     step;
   logic [DIGITS:0]   rip;    // rip[i]: digit i must change (all lower digits wrapped)

   bcd_digit_valid u_valid (
      .code (bus.ld_digit),
      .ok   (dig_ok)
   );

   assign bus.ld_ready = (state != COMMIT);
   assign xfer         = bus.ld_valid && bus.ld_ready;

   // Per-digit ripple: a digit steps when every lower digit rolled over;
   // it rolls over itself when it sits at the end of its range for the direction.
   assign rip[0] = 1'b1;
   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_t d;
      logic at_end;
      assign d        = q_r[g*BCD_W +: BCD_W];
      assign at_end   = bus.up ? (d == BCD_MAX) : (d == '0);
      assign rip[g+1] = rip[g] & at_end;
      assign step[g*BCD_W +: BCD_W] =
         !rip[g] ? d :
         at_end  ? (bus.up ? bcd_t'(0) : BCD_MAX) :
                   (bus.up ? d + 4'd1 : d - 4'd1);
   end

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      shadow_n = shadow;
      q_n      = q_r;
      carry_n  = 1'b0;
      err_n    = 1'b0;
      case (state)
         IDLE: begin
            if (xfer) begin
               // a transfer wins over counting in the same cycle
               if (!dig_ok) begin
                  shadow_n = '0;
                  idx_n    = '0;
                  err_n    = 1'b1;
               end else begin
                  shadow_n[BCD_W-1:0] = bus.ld_digit;
                  if (DIGITS == 1) begin
                     state_n = COMMIT;
                     idx_n   = '0;
                  end else begin
                     state_n = LOAD;
                     idx_n   = IDX_W'(1);
                  end
               end
            end else if (bus.en) begin
               q_n     = step;
               carry_n = rip[DIGITS];
            end
         end
         LOAD: begin
            if (xfer) begin
               if (!dig_ok) begin
                  state_n  = IDLE;
                  shadow_n = '0;
                  idx_n    = '0;
                  err_n    = 1'b1;
               end else begin
                  for (int i = 0; i < DIGITS; i++) begin
                     if (idx == IDX_W'(i)) shadow_n[i*BCD_W +: BCD_W] = bus.ld_digit;
                  end
                  if (idx == IDX_W'(DIGITS-1)) begin
                     state_n = COMMIT;
                     idx_n   = '0;
                  end else begin
                     idx_n = idx + IDX_W'(1);
                  end
               end
            end
         end
         COMMIT: begin
            q_n     = shadow;
            state_n = IDLE;
            idx_n   = '0;
         end
         default: begin
            state_n = IDLE;
            idx_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         shadow  <= '0;
         q_r     <= '0;
         carry_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         shadow  <= shadow_n;
         q_r     <= q_n;
         carry_r <= carry_n;
         err_r   <= err_n;
      end
   end

   assign bus.q     = q_r;
   assign bus.carry = carry_r;
   assign bus.err   = err_r;

endmodule

// File: tb/tb_bcd_load_counter.sv
// Directed bench for bcd_load_counter with DIGITS=2.
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_load_counter;

   logic clk;
   logic rst;

   bcd_load_counter_if #(.DIGITS(2)) bus ();

   bcd_load_counter #(.DIGITS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       en;
      logic       up;
      logic       ldv;
      logic [3:0] dig;
      logic [7:0] q;
      logic       c;
      logic       e;
      logic       r;
   } vec_t;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic r_, input logic en_, input logic up_,
                               input logic ldv_, input logic [3:0] dig_,
                               input logic [7:0] q_, input logic c_,
                               input logic e_, input logic rdy_);
      vec_t v;
      v.rst = r_; v.en = en_; v.up = up_; v.ldv = ldv_; v.dig = dig_;
      v.q = q_; v.c = c_; v.e = e_; v.r = rdy_;
      return v;
   endfunction

   // drive away from the active edge, step one clock, sample 1ns after the edge
   task automatic apply(input logic r_, input logic en_, input logic up_,
                        input logic ldv_, input logic [3:0] dig_);
      @(negedge clk);
      rst          = r_;
      bus.en       = en_;
      bus.up       = up_;
      bus.ld_valid = ldv_;
      bus.ld_digit = dig_;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] q_, input logic c_,
                        input logic e_, input logic rdy_);
      n_vec++;
      if (bus.q !== q_ || bus.carry !== c_ || bus.err !== e_ || bus.ld_ready !== rdy_) begin
         n_bad++;
         $display("FAIL %s: got q=%h carry=%b err=%b rdy=%b, want q=%h carry=%b err=%b rdy=%b",
                  name, bus.q, bus.carry, bus.err, bus.ld_ready, q_, c_, e_, rdy_);
      end
   endtask

   initial begin
      int v;
      logic [7:0] eq;

      rst = 1'b1; bus.en = 1'b0; bus.up = 1'b1; bus.ld_valid = 1'b0; bus.ld_digit = 4'd0;

      //             rst en up ldv dig      q   c  e  rdy
      vq.push_back(mk(1, 0, 1, 0, 4'h0, 8'h00, 0, 0, 1)); // 0 reset
      vq.push_back(mk(1, 0, 1, 0, 4'h0, 8'h00, 0, 0, 1)); // 1
      vq.push_back(mk(0, 0, 1, 0, 4'h0, 8'h00, 0, 0, 1)); // 2 hold
      vq.push_back(mk(0, 0, 1, 1, 4'h8, 8'h00, 0, 0, 1)); // 3 load 8 -> LOAD
      vq.push_back(mk(0, 0, 1, 1, 4'h9, 8'h00, 0, 0, 0)); // 4 load 9 -> COMMIT
      vq.push_back(mk(0, 0, 1, 0, 4'h0, 8'h98, 0, 0, 1)); // 5 q=98, no carry on load
      vq.push_back(mk(0, 1, 1, 0, 4'h0, 8'h99, 0, 0, 1)); // 6 up
      vq.push_back(mk(0, 1, 1, 0, 4'h0, 8'h00, 1, 0, 1)); // 7 up-wrap
      vq.push_back(mk(0, 0, 1, 0, 4'h0, 8'h00, 0, 0, 1)); // 8 carry drops
      vq.push_back(mk(0, 1, 0, 0, 4'h0, 8'h99, 1, 0, 1)); // 9 down-wrap
      vq.push_back(mk(0, 1, 0, 0, 4'h0, 8'h98, 0, 0, 1)); // 10 down
      vq.push_back(mk(0, 1, 1, 1, 4'h7, 8'h98, 0, 0, 1)); // 11 collision: no count
      vq.push_back(mk(0, 1, 1, 1, 4'h4, 8'h98, 0, 0, 0)); // 12 frozen, COMMIT
      vq.push_back(mk(0, 1, 1, 0, 4'h0, 8'h47, 0, 0, 1)); // 13 loaded 47
      vq.push_back(mk(0, 1, 1, 0, 4'h0, 8'h48, 0, 0, 1)); // 14 counts again
      vq.push_back(mk(0, 0, 1, 1, 4'h5, 8'h48, 0, 0, 1)); // 15 load 25
      vq.push_back(mk(0, 0, 1, 1, 4'h2, 8'h48, 0, 0, 0)); // 16
      vq.push_back(mk(0, 0, 1, 0, 4'h0, 8'h25, 0, 0, 1)); // 17
      vq.push_back(mk(0, 0, 1, 1, 4'h3, 8'h25, 0, 0, 1)); // 18 digit 3
      vq.push_back(mk(0, 0, 1, 1, 4'hB, 8'h25, 0, 1, 1)); // 19 bad digit -> err
      vq.push_back(mk(0, 0, 1, 0, 4'h0, 8'h25, 0, 0, 1)); // 20 err single pulse
      vq.push_back(mk(0, 0, 1, 1, 4'h1, 8'h25, 0, 0, 1)); // 21 load 61
      vq.push_back(mk(0, 0, 1, 1, 4'h6, 8'h25, 0, 0, 0)); // 22
      vq.push_back(mk(0, 0, 1, 0, 4'h0, 8'h61, 0, 0, 1)); // 23
      vq.push_back(mk(0, 1, 1, 1, 4'hF, 8'h61, 0, 1, 1)); // 24 bad digit in IDLE, no count
      vq.push_back(mk(0, 1, 1, 0, 4'h0, 8'h62, 0, 0, 1)); // 25
      vq.push_back(mk(0, 1, 1, 1, 4'h3, 8'h62, 0, 0, 1)); // 26 enter LOAD
      for (int i = 0; i < 5; i++)
         vq.push_back(mk(0, 1, 1, 0, 4'h0, 8'h62, 0, 0, 1)); // 27..31 stall
      vq.push_back(mk(0, 0, 1, 1, 4'h0, 8'h62, 0, 0, 0)); // 32 digit 0 -> COMMIT
      vq.push_back(mk(0, 0, 1, 0, 4'h0, 8'h03, 0, 0, 1)); // 33 q=03
      vq.push_back(mk(0, 0, 1, 1, 4'h5, 8'h03, 0, 0, 1)); // 34 enter LOAD
      vq.push_back(mk(1, 1, 1, 1, 4'h7, 8'h00, 0, 0, 1)); // 35 reset mid-LOAD
      vq.push_back(mk(1, 0, 1, 0, 4'h0, 8'h00, 0, 0, 1)); // 36
      vq.push_back(mk(0, 0, 1, 1, 4'h1, 8'h00, 0, 0, 1)); // 37 IDLE again, slot 0
      vq.push_back(mk(0, 0, 1, 1, 4'h2, 8'h00, 0, 0, 0)); // 38
      vq.push_back(mk(0, 0, 1, 0, 4'h0, 8'h21, 0, 0, 1)); // 39

      for (int i = 0; i < vq.size(); i++) begin
         apply(vq[i].rst, vq[i].en, vq[i].up, vq[i].ldv, vq[i].dig);
         check($sformatf("vec%0d", i), vq[i].q, vq[i].c, vq[i].e, vq[i].r);
      end

      // long up-run from 21 through a full wrap, against a decimal model
      v = 21;
      for (int i = 0; i < 110; i++) begin
         apply(0, 1, 1, 0, 4'h0);
         v  = (v + 1) % 100;
         eq = {4'(v / 10), 4'(v % 10)};
         check($sformatf("up%0d", i), eq, (v == 0), 1'b0, 1'b1);
      end

      // down-run across the 00 -> 99 boundary
      for (int i = 0; i < 40; i++) begin
         apply(0, 1, 0, 0, 4'h0);
         v  = (v + 99) % 100;
         eq = {4'(v / 10), 4'(v % 10)};
         check($sformatf("dn%0d", i), eq, (v == 99), 1'b0, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
